// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch queue between the dual-issue I-cache and
// decode. Tags 1- or 2-instruction bundles with their fetch PC, buffers them
// in a small FIFO and redirects the cache on an execute-stage branch.
// Optional build macro IFQ_BYPASS_EN: when defined, a bundle arriving at an
// empty queue in ST_RUN is forwarded to decode in the same cycle.
module if_fetch_queue #(
   parameter int                        ADDRESS_LENGTH = 30,
   parameter int                        INSTR_LENGTH   = 32,
   parameter int                        DEPTH          = 4,
   parameter logic [ADDRESS_LENGTH-1:0] RESET_ADDR     = '0
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_ic_instr_valid,
   input  logic [INSTR_LENGTH-1:0]   i_ic_instr0,
   input  logic [INSTR_LENGTH-1:0]   i_ic_instr1,
   output logic                      o_ic_ready,
   output logic                      o_ic_brch,
   output logic [ADDRESS_LENGTH-1:0] o_ic_brch_addr,
   output logic                      o_id_valid,
   output logic [INSTR_LENGTH-1:0]   o_id_instr0,
   output logic [INSTR_LENGTH-1:0]   o_id_instr1,
   output logic                      o_id_pair,
   output logic [ADDRESS_LENGTH-1:0] o_id_pc,
   input  logic                      i_id_ready,
   input  logic                      i_ex_brch,
   input  logic [ADDRESS_LENGTH-1:0] i_ex_brch_addr
);

   localparam int              PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(DEPTH);

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_REDIRECT = 1'b1
   } state_t;

   state_t                     state;
   state_t                     state_nxt;

   logic [PTR_W-1:0]           wr_ptr;
   logic [PTR_W-1:0]           rd_ptr;
   logic [PTR_W:0]             count;
   logic [ADDRESS_LENGTH-1:0]  fetch_pc;
   logic [ADDRESS_LENGTH-1:0]  brch_addr;

   logic [INSTR_LENGTH-1:0]    mem_instr0 [DEPTH];
   logic [INSTR_LENGTH-1:0]    mem_instr1 [DEPTH];
   logic                       mem_pair   [DEPTH];
   logic [ADDRESS_LENGTH-1:0]  mem_pc     [DEPTH];

   logic                       ic_ready;
   logic                       ic_brch;
   logic                       fifo_empty;
   logic                       accept;
   logic                       write_fifo;
   logic                       pop_fifo;
   logic                       in_pair;
   logic [INSTR_LENGTH-1:0]    in_instr1;
   logic [ADDRESS_LENGTH-1:0]  pc_step;

   // An unpaired bundle carries no second instruction; store zero so decode
   // never sees stale cache data in instr1.
   assign in_pair    = i_ic_instr0[INSTR_LENGTH-1];
   assign in_instr1  = in_pair ? i_ic_instr1 : '0;
   assign pc_step    = in_pair ? ADDRESS_LENGTH'(2) : ADDRESS_LENGTH'(1);
   assign fifo_empty = (count == '0);

   // Next-state and cache-side handshake decode.
   always_comb begin
      state_nxt = state;
      ic_ready  = 1'b0;
      ic_brch   = 1'b0;
      case (state)
         ST_RUN: begin
            ic_ready = (count < DEPTH_C);
            if (i_ex_brch) state_nxt = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            // The cache latches the target on the first edge it presents a
            // bundle; a newer branch keeps us here with the fresh target.
            ic_ready = 1'b1;
            ic_brch  = 1'b1;
            if (i_ex_brch)             state_nxt = ST_REDIRECT;
            else if (i_ic_instr_valid) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   assign o_ic_ready     = ic_ready & ~i_rst;
   assign o_ic_brch      = ic_brch;
   assign o_ic_brch_addr = brch_addr;

   // A taken branch overrides any push or pop presented in the same cycle.
   assign accept   = i_ic_instr_valid & o_ic_ready & (state == ST_RUN) & ~i_ex_brch;
   assign pop_fifo = ~fifo_empty & i_id_ready & ~i_ex_brch;

`ifdef IFQ_BYPASS_EN
   logic bypass;
   assign bypass     = (state == ST_RUN) & fifo_empty & i_ic_instr_valid & ~i_rst;
   // A bypassed bundle that decode takes immediately never occupies a slot.
   assign write_fifo = accept & ~(bypass & i_id_ready);

   // Head presentation: FIFO head, or the incoming bundle when empty.
   always_comb begin
      o_id_valid  = 1'b0;
      o_id_instr0 = '0;
      o_id_instr1 = '0;
      o_id_pair   = 1'b0;
      o_id_pc     = '0;
      if (!fifo_empty) begin
         o_id_valid  = 1'b1;
         o_id_instr0 = mem_instr0[rd_ptr];
         o_id_instr1 = mem_instr1[rd_ptr];
         o_id_pair   = mem_pair[rd_ptr];
         o_id_pc     = mem_pc[rd_ptr];
      end else if (bypass) begin
         o_id_valid  = 1'b1;
         o_id_instr0 = i_ic_instr0;
         o_id_instr1 = in_instr1;
         o_id_pair   = in_pair;
         o_id_pc     = fetch_pc;
      end
   end
`else
   assign write_fifo = accept;

   // Head presentation from FIFO storage only; zero while empty.
   always_comb begin
      o_id_valid  = 1'b0;
      o_id_instr0 = '0;
      o_id_instr1 = '0;
      o_id_pair   = 1'b0;
      o_id_pc     = '0;
      if (!fifo_empty) begin
         o_id_valid  = 1'b1;
         o_id_instr0 = mem_instr0[rd_ptr];
         o_id_instr1 = mem_instr1[rd_ptr];
         o_id_pair   = mem_pair[rd_ptr];
         o_id_pc     = mem_pc[rd_ptr];
      end
   end
`endif

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= ST_RUN;
      else       state <= state_nxt;
   end

   // Queue control: occupancy, pointers, fetch PC and redirect target.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fetch_pc  <= RESET_ADDR;
         brch_addr <= RESET_ADDR;
      end else if (i_ex_brch) begin
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fetch_pc  <= i_ex_brch_addr;
         brch_addr <= i_ex_brch_addr;
      end else begin
         if (write_fifo) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_fifo)   rd_ptr <= rd_ptr + PTR_W'(1);
         if (write_fifo && !pop_fifo)      count <= count + (PTR_W+1)'(1);
         else if (!write_fifo && pop_fifo) count <= count - (PTR_W+1)'(1);
         if (accept) fetch_pc <= fetch_pc + pc_step;
      end
   end

   // Bundle storage; payload needs no reset since count gates visibility.
   always_ff @(posedge i_clk) begin
      if (write_fifo) begin
         mem_instr0[wr_ptr] <= i_ic_instr0;
         mem_instr1[wr_ptr] <= in_instr1;
         mem_pair[wr_ptr]   <= in_pair;
         mem_pc[wr_ptr]     <= fetch_pc;
      end
   end

   // The cache must never present a bundle to a full queue while running.
   a_no_push_when_full: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_ic_instr_valid && !o_ic_ready && (state == ST_RUN)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue (DEPTH=4, RESET_ADDR=0x100).
module tb_if_fetch_queue;

   localparam int          AL     = 30;
   localparam int          IL     = 32;
   localparam int          DEPTH  = 4;
   localparam logic [29:0] RST_PC = 30'h100;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_ic_instr_valid;
   logic [IL-1:0] i_ic_instr0;
   logic [IL-1:0] i_ic_instr1;
   logic          o_ic_ready;
   logic          o_ic_brch;
   logic [AL-1:0] o_ic_brch_addr;
   logic          o_id_valid;
   logic [IL-1:0] o_id_instr0;
   logic [IL-1:0] o_id_instr1;
   logic          o_id_pair;
   logic [AL-1:0] o_id_pc;
   logic          i_id_ready;
   logic          i_ex_brch;
   logic [AL-1:0] i_ex_brch_addr;

   int n_assert = 0;
   int n_fail   = 0;

   if_fetch_queue #(
      .ADDRESS_LENGTH (AL),
      .INSTR_LENGTH   (IL),
      .DEPTH          (DEPTH),
      .RESET_ADDR     (RST_PC)
   ) dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_ic_instr_valid (i_ic_instr_valid),
      .i_ic_instr0      (i_ic_instr0),
      .i_ic_instr1      (i_ic_instr1),
      .o_ic_ready       (o_ic_ready),
      .o_ic_brch        (o_ic_brch),
      .o_ic_brch_addr   (o_ic_brch_addr),
      .o_id_valid       (o_id_valid),
      .o_id_instr0      (o_id_instr0),
      .o_id_instr1      (o_id_instr1),
      .o_id_pair        (o_id_pair),
      .o_id_pc          (o_id_pc),
      .i_id_ready       (i_id_ready),
      .i_ex_brch        (i_ex_brch),
      .i_ex_brch_addr   (i_ex_brch_addr)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic bundle(input logic v, input logic [IL-1:0] a, input logic [IL-1:0] b);
      i_ic_instr_valid = v;
      i_ic_instr0      = a;
      i_ic_instr1      = b;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      bundle(1'b0, '0, '0);
      i_id_ready     = 1'b0;
      i_ex_brch      = 1'b0;
      i_ex_brch_addr = '0;
      tick();
      i_rst = 1'b0;
   endtask

   initial begin
      // Reset state
      i_rst = 1'b1;
      bundle(1'b0, '0, '0);
      i_id_ready = 1'b0; i_ex_brch = 1'b0; i_ex_brch_addr = '0;
      #2;
      chk("rst_ic_ready", 64'(o_ic_ready), 64'h0);
      chk("rst_id_valid", 64'(o_id_valid), 64'h0);
      chk("rst_ic_brch", 64'(o_ic_brch), 64'h0);
      chk("rst_brch_addr", 64'(o_ic_brch_addr), 64'h100);
      chk("rst_id_pc", 64'(o_id_pc), 64'h0);
      chk("rst_id_pair", 64'(o_id_pair), 64'h0);
      tick();
      i_rst = 1'b0;
      #1;
      chk("post_rst_ready", 64'(o_ic_ready), 64'h1);

      // Unpaired bundles, decode always ready
      i_id_ready = 1'b1;
      bundle(1'b1, 32'h00000013, 32'hFFFF_FFFF);
      tick();
      chk("up0_valid", 64'(o_id_valid), 64'h1);
      chk("up0_pc", 64'(o_id_pc), 64'h100);
      chk("up0_instr0", 64'(o_id_instr0), 64'h13);
      chk("up0_instr1", 64'(o_id_instr1), 64'h0);
      chk("up0_pair", 64'(o_id_pair), 64'h0);
      bundle(1'b1, 32'h00000033, 32'h0);
      tick();
      chk("up1_pc", 64'(o_id_pc), 64'h101);
      chk("up1_instr0", 64'(o_id_instr0), 64'h33);
      bundle(1'b0, '0, '0);
      tick();
      chk("up_drained", 64'(o_id_valid), 64'h0);

      // Paired bundle advances PC by 2
      do_reset();
      i_id_ready = 1'b1;
      bundle(1'b1, 32'h80000013, 32'h00000093);
      tick();
      chk("pr_pair", 64'(o_id_pair), 64'h1);
      chk("pr_pc", 64'(o_id_pc), 64'h100);
      chk("pr_instr1", 64'(o_id_instr1), 64'h93);
      bundle(1'b1, 32'h00000013, 32'h00000055);
      tick();
      chk("pr_next_pc", 64'(o_id_pc), 64'h102);
      chk("pr_next_pair", 64'(o_id_pair), 64'h0);
      chk("pr_next_instr1", 64'(o_id_instr1), 64'h0);
      bundle(1'b0, '0, '0);
      tick();

      // Fill to DEPTH with decode stalled, then drain in order
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         bundle(1'b1, 32'(32'h10 + i), 32'h0);
         tick();
         chk("fill_ready", 64'(o_ic_ready), (i == DEPTH-1) ? 64'h0 : 64'h1);
      end
      bundle(1'b0, '0, '0);
      tick();
      chk("full_ready_hold", 64'(o_ic_ready), 64'h0);
      chk("full_head_pc", 64'(o_id_pc), 64'h100);
      chk("full_head_instr", 64'(o_id_instr0), 64'h10);
      i_id_ready = 1'b1;
      for (int i = 1; i < DEPTH; i++) begin
         tick();
         chk("drain_pc", 64'(o_id_pc), 64'(64'h100 + i));
         chk("drain_instr", 64'(o_id_instr0), 64'(64'h10 + i));
         chk("drain_ready", 64'(o_ic_ready), 64'h1);
      end
      tick();
      chk("drain_empty", 64'(o_id_valid), 64'h0);
      bundle(1'b1, 32'h00000014, 32'h0);
      tick();
      chk("fifth_pc", 64'(o_id_pc), 64'h104);
      chk("fifth_instr", 64'(o_id_instr0), 64'h14);
      bundle(1'b0, '0, '0);
      tick();

      // Branch with 3 queued entries and a concurrent push
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bundle(1'b1, 32'(32'h20 + i), 32'h0);
         tick();
      end
      chk("br_pre_pc", 64'(o_id_pc), 64'h100);
      bundle(1'b1, 32'h00000023, 32'h0);
      i_id_ready = 1'b1;
      i_ex_brch = 1'b1; i_ex_brch_addr = 30'h2A0;
      tick();
      i_ex_brch = 1'b0;
      bundle(1'b0, '0, '0);
      chk("br_flush_valid", 64'(o_id_valid), 64'h0);
      chk("br_ic_brch", 64'(o_ic_brch), 64'h1);
      chk("br_addr", 64'(o_ic_brch_addr), 64'h2A0);
      chk("br_ready", 64'(o_ic_ready), 64'h1);
      tick();
      chk("br_hold", 64'(o_ic_brch), 64'h1);
      chk("br_hold_valid", 64'(o_id_valid), 64'h0);
      bundle(1'b1, 32'h0000DEAD, 32'h0);
      tick();
      chk("br_exit", 64'(o_ic_brch), 64'h0);
      chk("br_dropped", 64'(o_id_valid), 64'h0);
      bundle(1'b1, 32'h00000077, 32'h0);
      tick();
      chk("br_target_pc", 64'(o_id_pc), 64'h2A0);
      chk("br_target_instr", 64'(o_id_instr0), 64'h77);
      bundle(1'b0, '0, '0);
      tick();

      // Back-to-back branches while redirecting
      do_reset();
      i_ex_brch = 1'b1; i_ex_brch_addr = 30'h40;
      tick();
      chk("bb_addr0", 64'(o_ic_brch_addr), 64'h40);
      i_ex_brch_addr = 30'h80;
      bundle(1'b1, 32'h000000AA, 32'h0);
      tick();
      i_ex_brch = 1'b0;
      chk("bb_stay", 64'(o_ic_brch), 64'h1);
      chk("bb_addr1", 64'(o_ic_brch_addr), 64'h80);
      bundle(1'b1, 32'h000000AB, 32'h0);
      tick();
      chk("bb_exit", 64'(o_ic_brch), 64'h0);
      chk("bb_dropped", 64'(o_id_valid), 64'h0);
      bundle(1'b1, 32'h000000BB, 32'h0);
      tick();
      chk("bb_pc", 64'(o_id_pc), 64'h80);
      chk("bb_instr", 64'(o_id_instr0), 64'hBB);

      // Asynchronous reset in the middle of a drain
      bundle(1'b1, 32'h000000CC, 32'h0);
      tick();
      bundle(1'b0, '0, '0);
      i_id_ready = 1'b1;
      tick();
      chk("ar_pre_pc", 64'(o_id_pc), 64'h81);
      #3;
      i_rst = 1'b1;
      #1;
      chk("ar_valid", 64'(o_id_valid), 64'h0);
      chk("ar_pc", 64'(o_id_pc), 64'h0);
      chk("ar_instr0", 64'(o_id_instr0), 64'h0);
      chk("ar_ready", 64'(o_ic_ready), 64'h0);
      chk("ar_brch", 64'(o_ic_brch), 64'h0);
      chk("ar_brch_addr", 64'(o_ic_brch_addr), 64'h100);
      #1;
      i_rst = 1'b0;
      bundle(1'b1, 32'h00000013, 32'h0);
      #1;
`ifdef IFQ_BYPASS_EN
      chk("bp_valid", 64'(o_id_valid), 64'h1);
      chk("bp_pc", 64'(o_id_pc), 64'h100);
      chk("bp_instr", 64'(o_id_instr0), 64'h13);
      tick();
      bundle(1'b0, '0, '0);
      #1;
      chk("bp_consumed", 64'(o_id_valid), 64'h0);
`else
      chk("nb_no_comb", 64'(o_id_valid), 64'h0);
      tick();
      bundle(1'b0, '0, '0);
      chk("nb_valid", 64'(o_id_valid), 64'h1);
      chk("nb_pc", 64'(o_id_pc), 64'h100);
      tick();
      chk("nb_consumed", 64'(o_id_valid), 64'h0);
`endif
      i_id_ready = 1'b0;
      bundle(1'b1, 32'h00000033, 32'h0);
      tick();
      bundle(1'b0, '0, '0);
      chk("ar_next_pc", 64'(o_id_pc), 64'h101);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
